// File: rtl/fnd_pkg.sv
// Shared constants and types for the six-digit FND scan controller.
package fnd_pkg;

  localparam int N_DIGITS = 6;
  localparam int SEL_W    = 3;

  localparam logic [N_DIGITS-1:0] DIGIT_OFF = 6'b111111;

  typedef enum logic {
    DRIVE = 1'b0,
    BLANK = 1'b1
  } scan_state_e;

endpackage

// File: rtl/scan_slot_cnt.sv
// Modulo-TICK_DIV slot counter with enable and synchronous reset.
// wrap marks the enabled cycle on which the counter rolls over to zero.
module scan_slot_cnt #(
  parameter int TICK_DIV = 100_000,
  parameter int CNT_W    = $clog2(TICK_DIV)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  assign wrap = en && (cnt_reg == CNT_LAST);

  always_comb begin
    cnt_next = cnt_reg;
    if (wrap) begin
      cnt_next = '0;
    end else if (en) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Six-digit FND scan controller: digit select, active-low enables and
// decimal point, with a dark interval at the end of every slot.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int TICK_DIV  = 100_000,
  parameter int BLANK_CYC = 1_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [N_DIGITS-1:0] blank_mask,
  input  logic [N_DIGITS-1:0] dp_in,
  output logic [SEL_W-1:0]    sel,
  output logic [N_DIGITS-1:0] digit_n,
  output logic                dp_n,
  output logic                frame_tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] DRIVE_END = CNT_W'(TICK_DIV - BLANK_CYC);
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(N_DIGITS - 1);

  logic [CNT_W-1:0]    cnt;
  logic                wrap;
  scan_state_e         state;

  logic [SEL_W-1:0]    sel_reg, sel_next;
  logic [N_DIGITS-1:0] digit_n_reg, digit_n_next;
  logic                dp_n_reg, dp_n_next;
  logic                frame_tick_reg, frame_tick_next;

  logic [N_DIGITS-1:0] digit_on;
  logic [N_DIGITS-1:0] dp_on;
  logic                lit_ok;

  scan_slot_cnt #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_slot_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .cnt   (cnt),
    .wrap  (wrap)
  );

  always_comb begin
    state = (cnt < DRIVE_END) ? DRIVE : BLANK;
  end

  // One-hot digit decode; an out-of-range sel (6/7) matches no digit and stays dark.
  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
    assign digit_on[gi] = (sel_reg == SEL_W'(gi)) && !blank_mask[gi];
    assign dp_on[gi]    = digit_on[gi] && dp_in[gi];
  end

  assign lit_ok = en && (state == DRIVE);

  always_comb begin
    sel_next        = sel_reg;
    frame_tick_next = 1'b0;
    if (wrap) begin
      if (sel_reg == SEL_LAST) begin
        sel_next        = '0;
        frame_tick_next = 1'b1;
      end else if (sel_reg > SEL_LAST) begin
        sel_next = '0;
      end else begin
        sel_next = sel_reg + 1'b1;
      end
    end
  end

  always_comb begin
    digit_n_next = DIGIT_OFF;
    dp_n_next    = 1'b1;
    if (lit_ok) begin
      digit_n_next = ~digit_on;
      dp_n_next    = ~(|dp_on);
    end
  end

  // sel only moves on the wrap edge, whose pre-edge state is BLANK, so the
  // mux settles while every digit is still off.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_reg        <= '0;
      digit_n_reg    <= DIGIT_OFF;
      dp_n_reg       <= 1'b1;
      frame_tick_reg <= 1'b0;
    end else begin
      sel_reg        <= sel_next;
      digit_n_reg    <= digit_n_next;
      dp_n_reg       <= dp_n_next;
      frame_tick_reg <= frame_tick_next;
    end
  end

  assign sel        = sel_reg;
  assign digit_n    = digit_n_reg;
  assign dp_n       = dp_n_reg;
  assign frame_tick = frame_tick_reg;

endmodule

// File: doc/fnd_scan_ctrl.md
# fnd_scan_ctrl

Time-multiplexed scan controller for the six-digit FND display. It generates the 3-bit `sel` that drives the 6:1 digit mux, and the matching active-low digit enables and decimal point. A blanking interval with all digits off separates slots, so `sel` changes only while the display is dark and adjacent digits cannot ghost. It also emits a one-cycle `frame_tick` per complete six-digit scan for downstream blink and brightness logic.

## Interface
- `TICK_DIV`, default 100_000: clock cycles per digit slot. Must be ≥ 2.
- `BLANK_CYC`, default 1_000: cycles at the end of each slot with all digits off. Must satisfy 1 ≤ `BLANK_CYC` < `TICK_DIV`.
- `clk`  in  1  system clock. Single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  scan enable. When 0, the scan freezes and the display goes dark.
- `blank_mask`  in  6  bit i = 1 forces digit i off during its drive window.
- `dp_in`  in  6  bit i = 1 lights the decimal point while digit i is driven.
- `sel`  out  3  digit index 0..5 to the mux.
- `digit_n`  out  6  active-low digit enables. At most one bit is low at any time.
- `dp_n`  out  1  active-low decimal point.
- `frame_tick`  out  1  one-cycle pulse when `sel` wraps from 5 to 0.

## Operation
- Slot counter `cnt` (width `$clog2(TICK_DIV)`):
  - Counts 0..`TICK_DIV`-1 when `en` = 1.
  - Wraps to 0 after `TICK_DIV`-1.
- Two states, decoded from `cnt`:
  - DRIVE: `cnt` < `TICK_DIV`-`BLANK_CYC`.
  - BLANK: otherwise.
- Slot advance, on the edge where `cnt` = `TICK_DIV`-1 and `en` = 1:
  - `sel` increments.
  - `sel` = 5 wraps to 0, and `frame_tick` is 1 for that next cycle only.
- `digit_n`, `dp_n`, `frame_tick` are registered. Each edge they are loaded from the pre-edge `state`, `sel`, `blank_mask`, `dp_in`:
  - DRIVE, `en` = 1, `blank_mask[sel]` = 0: `digit_n` = ~(1 << `sel`) and `dp_n` = ~`dp_in[sel]`.
  - Any other case: `digit_n` = 6'b111111 and `dp_n` = 1.
- `en` = 0:
  - `cnt` and `sel` hold.
  - `digit_n` = all ones and `dp_n` = 1 from the next edge.
  - `frame_tick` = 0.
  - On re-enable, counting resumes from the held `cnt`/`sel`.
- `blank_mask` and `dp_in` are sampled every cycle. A change mid-slot takes effect on the next edge.
- `sel` values 6 and 7 are unreachable. If forced, the next advance returns `sel` to 0 and no `frame_tick` is emitted.

## Timing
- Reset values: `cnt` = 0, `sel` = 0, `digit_n` = 6'b111111, `dp_n` = 1, `frame_tick` = 0.
- `reset` overrides `en` and takes effect at the first edge where it is sampled high, including mid-slot or mid-blank.
- Latency: `digit_n`/`dp_n` lag the `cnt`/`sel` state by exactly one cycle.
  - The first digit-0 enable appears the cycle after the first post-reset edge with `en` = 1.
- `sel` changes only at the BLANK→DRIVE boundary. At that edge `digit_n` still shows all ones from the previous BLANK cycle, so the mux has at least one full cycle to settle before its digit is enabled.
- Per slot: `TICK_DIV`-`BLANK_CYC` driven cycles, then `BLANK_CYC` dark cycles.
- Frame period is 6·`TICK_DIV` cycles, with exactly one `frame_tick` per frame.

## Structure
- Package `fnd_pkg` holds:
  - `N_DIGITS` = 6 and `SEL_W` = 3.
  - `DIGIT_OFF` = 6'b111111.
  - State enum {DRIVE, BLANK}.
- One sub-module, `scan_slot_cnt`: a parameterised modulo-`TICK_DIV` counter with enable and synchronous reset. It outputs `cnt` and a `wrap` strobe.
- The top module holds `sel`, the state decode and the output registers.

## Test plan
All scenarios use `TICK_DIV` = 10, `BLANK_CYC` = 2.
- Reset hold, then release with `en` = 1, `blank_mask` = 0:
  - `digit_n` = 111111 during reset.
  - 111110 for cycles 1–8 after release, then 111111 for 2 cycles.
  - `sel` = 1 and `digit_n` = 111101 follow.
- Run 60 cycles:
  - `sel` sequence is 0..5 then back to 0.
  - `frame_tick` pulses once, at cycle 60.
  - No cycle ever has two `digit_n` bits low.
- `blank_mask` = 6'b000100, `dp_in` = 6'b000100: in slot 2, `digit_n` stays 111111 and `dp_n` = 1. Other slots behave normally.
- `dp_in` = 6'b000001 with no mask: `dp_n` = 0 only during digit 0's 8 driven cycles.
- Drop `en` at `cnt` = 4 in slot 3 for 5 cycles:
  - Display goes dark the next cycle.
  - `sel` stays 3.
  - On resume, 4 more driven cycles follow, then blank.
- Assert `reset` at `cnt` = 9 with `sel` = 5: `sel` = 0, no `frame_tick`, and `digit_n` = 111111 on the next cycle.
